// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: one single-position step per clock behind a start/busy/done handshake.
// Optional SEQ_SHIFT_ROTATE_EN adds a rot input that turns shift ops into rotates.
module seq_shift_unit #(
  parameter int n  = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    c,
  input  logic [n-1:0]  din,
  input  logic [AW-1:0] amt,
`ifdef SEQ_SHIFT_ROTATE_EN
  input  logic          rot,
`endif
  output logic          busy,
  output logic          done,
  output logic [n-1:0]  dout
);

  localparam logic [1:0] OP_SHL  = 2'b00;
  localparam logic [1:0] OP_PASS = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [n-1:0]  r_reg, r_dout, w_step;
  logic [1:0]    r_op;
  logic [AW-1:0] r_cnt;
  logic          r_rot, w_rot, w_load, w_short, w_last;

  // A new request is taken in IDLE and also in DONE, so ops can run back to back.
  assign w_load  = start && (r_state != S_SHIFT);
  assign w_short = (c == OP_PASS) || (c == OP_CLR) || (amt == '0);
  assign w_last  = (r_cnt == AW'(1));

`ifdef SEQ_SHIFT_ROTATE_EN
  assign w_rot = r_rot;
`else
  assign w_rot = 1'b0;
`endif

  always_comb begin
    w_step = r_reg;
    case (r_op)
      OP_SHL:  w_step = {r_reg[n-2:0], w_rot ? r_reg[n-1] : 1'b0};
      OP_SHR:  w_step = {w_rot ? r_reg[0] : 1'b0, r_reg[n-1:1]};
      OP_CLR:  w_step = '0;
      default: w_step = r_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = w_short ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = w_short ? S_DONE : S_SHIFT;
        else       w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg  <= '0;
      r_dout <= '0;
      r_op   <= OP_SHL;
      r_cnt  <= '0;
      r_rot  <= 1'b0;
    end else if (w_load) begin
      r_op  <= c;
      r_cnt <= amt;
`ifdef SEQ_SHIFT_ROTATE_EN
      r_rot <= rot;
`else
      r_rot <= 1'b0;
`endif
      r_reg <= (c == OP_CLR) ? '0 : din;
      // Short ops finish at the load edge, so the result is published right away.
      if (w_short) r_dout <= (c == OP_CLR) ? '0 : din;
    end else if (r_state == S_SHIFT) begin
      r_reg <= w_step;
      r_cnt <= r_cnt - AW'(1);
      if (w_last) r_dout <= w_step;
    end
  end

  assign dout = r_dout;

endmodule
